// File: rtl/axi4_read_arbiter.sv
// Purpose: round-robin arbiter sharing one AXI4 read port (AR + R) between NUM_MASTERS requesters.
// Latency: 1 cycle arbitration (IDLE -> ADDR); AR and R paths are combinational pass-through once granted.
// Backpressure: one burst in flight; the grant is held from AR accept to the R beat with last; ready/valid mirrored to the granted requester only.
//
// Ports:
//   clock, reset                  rising-edge clock, async active-high reset
//   io_s_axi_ar_*                 per-requester AR channels, requester i at packed slice i
//   io_s_axi_r_valid/_ready       per-requester R handshake; R id/data/resp/last are broadcast
//   io_m_axi_ar_* / io_m_axi_r_*  single downstream AXI4 read port
module axi4_read_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int ID_WIDTH    = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_MASTERS-1:0]          io_s_axi_ar_valid,
  output logic [NUM_MASTERS-1:0]          io_s_axi_ar_ready,
  input  logic [NUM_MASTERS*ID_WIDTH-1:0] io_s_axi_ar_bits_id,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] io_s_axi_ar_bits_addr,
  input  logic [NUM_MASTERS*8-1:0]        io_s_axi_ar_bits_len,
  output logic [NUM_MASTERS-1:0]          io_s_axi_r_valid,
  input  logic [NUM_MASTERS-1:0]          io_s_axi_r_ready,
  output logic [ID_WIDTH-1:0]             io_s_axi_r_bits_id,
  output logic [DATA_WIDTH-1:0]           io_s_axi_r_bits_data,
  output logic [1:0]                      io_s_axi_r_bits_resp,
  output logic                            io_s_axi_r_bits_last,
  output logic                            io_m_axi_ar_valid,
  input  logic                            io_m_axi_ar_ready,
  output logic [ID_WIDTH-1:0]             io_m_axi_ar_bits_id,
  output logic [ADDR_WIDTH-1:0]           io_m_axi_ar_bits_addr,
  output logic [7:0]                      io_m_axi_ar_bits_len,
  input  logic                            io_m_axi_r_valid,
  output logic                            io_m_axi_r_ready,
  input  logic [ID_WIDTH-1:0]             io_m_axi_r_bits_id,
  input  logic [DATA_WIDTH-1:0]           io_m_axi_r_bits_data,
  input  logic [1:0]                      io_m_axi_r_bits_resp,
  input  logic                            io_m_axi_r_bits_last
);

  localparam int GW = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_grant_q, last_grant_d;
  logic [GW-1:0]   winner;
  logic            found;

  // Round-robin pick: first asserted valid scanning upward from last_grant+1.
  always_comb begin
    winner = last_grant_q;
    found  = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      if (!found && io_s_axi_ar_valid[(int'(last_grant_q) + i) % NUM_MASTERS]) begin
        winner = GW'((int'(last_grant_q) + i) % NUM_MASTERS);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_MASTERS - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // All handshake outputs decode from state_q, so an async reset drops them immediately.
  always_comb begin
    state_d           = state_q;
    grant_d           = grant_q;
    last_grant_d      = last_grant_q;
    io_s_axi_ar_ready = '0;
    io_s_axi_r_valid  = '0;
    io_m_axi_ar_valid = 1'b0;
    io_m_axi_r_ready  = 1'b0;
    io_m_axi_ar_bits_id   = io_s_axi_ar_bits_id[int'(grant_q)*ID_WIDTH +: ID_WIDTH];
    io_m_axi_ar_bits_addr = io_s_axi_ar_bits_addr[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
    io_m_axi_ar_bits_len  = io_s_axi_ar_bits_len[int'(grant_q)*8 +: 8];

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = winner;
          state_d = ADDR;
        end
      end
      ADDR: begin
        // AXI requires ar_valid to be held, so the granted request cannot vanish here.
        io_m_axi_ar_valid          = 1'b1;
        io_s_axi_ar_ready[grant_q] = io_m_axi_ar_ready;
        if (io_m_axi_ar_ready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        io_s_axi_r_valid[grant_q] = io_m_axi_r_valid;
        io_m_axi_r_ready          = io_s_axi_r_ready[grant_q];
        if (io_m_axi_r_valid && io_s_axi_r_ready[grant_q] && io_m_axi_r_bits_last) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // R payload is broadcast; only the granted requester sees valid.
  assign io_s_axi_r_bits_id   = io_m_axi_r_bits_id;
  assign io_s_axi_r_bits_data = io_m_axi_r_bits_data;
  assign io_s_axi_r_bits_resp = io_m_axi_r_bits_resp;
  assign io_s_axi_r_bits_last = io_m_axi_r_bits_last;

endmodule

// File: tb/tb_axi4_read_arbiter.sv
// Purpose: scoreboard bench for axi4_read_arbiter with directed bursts from two requesters.
// Latency: expectations are queued by stimulus; a negedge monitor pops them on each handshake.
// Backpressure: downstream ar_ready stalls and requester r_ready toggling are exercised.
module tb_axi4_read_arbiter;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;

  logic               clock;
  logic               reset;
  logic [NM-1:0]      io_s_axi_ar_valid;
  logic [NM-1:0]      io_s_axi_ar_ready;
  logic [NM*IW-1:0]   io_s_axi_ar_bits_id;
  logic [NM*AW-1:0]   io_s_axi_ar_bits_addr;
  logic [NM*8-1:0]    io_s_axi_ar_bits_len;
  logic [NM-1:0]      io_s_axi_r_valid;
  logic [NM-1:0]      io_s_axi_r_ready;
  logic [IW-1:0]      io_s_axi_r_bits_id;
  logic [DW-1:0]      io_s_axi_r_bits_data;
  logic [1:0]         io_s_axi_r_bits_resp;
  logic               io_s_axi_r_bits_last;
  logic               io_m_axi_ar_valid;
  logic               io_m_axi_ar_ready;
  logic [IW-1:0]      io_m_axi_ar_bits_id;
  logic [AW-1:0]      io_m_axi_ar_bits_addr;
  logic [7:0]         io_m_axi_ar_bits_len;
  logic               io_m_axi_r_valid;
  logic               io_m_axi_r_ready;
  logic [IW-1:0]      io_m_axi_r_bits_id;
  logic [DW-1:0]      io_m_axi_r_bits_data;
  logic [1:0]         io_m_axi_r_bits_resp;
  logic               io_m_axi_r_bits_last;

  axi4_read_arbiter #(
    .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)
  ) dut (
    .clock(clock), .reset(reset),
    .io_s_axi_ar_valid(io_s_axi_ar_valid), .io_s_axi_ar_ready(io_s_axi_ar_ready),
    .io_s_axi_ar_bits_id(io_s_axi_ar_bits_id), .io_s_axi_ar_bits_addr(io_s_axi_ar_bits_addr),
    .io_s_axi_ar_bits_len(io_s_axi_ar_bits_len),
    .io_s_axi_r_valid(io_s_axi_r_valid), .io_s_axi_r_ready(io_s_axi_r_ready),
    .io_s_axi_r_bits_id(io_s_axi_r_bits_id), .io_s_axi_r_bits_data(io_s_axi_r_bits_data),
    .io_s_axi_r_bits_resp(io_s_axi_r_bits_resp), .io_s_axi_r_bits_last(io_s_axi_r_bits_last),
    .io_m_axi_ar_valid(io_m_axi_ar_valid), .io_m_axi_ar_ready(io_m_axi_ar_ready),
    .io_m_axi_ar_bits_id(io_m_axi_ar_bits_id), .io_m_axi_ar_bits_addr(io_m_axi_ar_bits_addr),
    .io_m_axi_ar_bits_len(io_m_axi_ar_bits_len),
    .io_m_axi_r_valid(io_m_axi_r_valid), .io_m_axi_r_ready(io_m_axi_r_ready),
    .io_m_axi_r_bits_id(io_m_axi_r_bits_id), .io_m_axi_r_bits_data(io_m_axi_r_bits_data),
    .io_m_axi_r_bits_resp(io_m_axi_r_bits_resp), .io_m_axi_r_bits_last(io_m_axi_r_bits_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          port;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_exp_t;

  typedef struct {
    int          port;
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  ar_exp_t exp_ar[$];
  r_exp_t  exp_r[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ar(input int port, input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    ar_exp_t e;
    e.port = port; e.id = id; e.addr = addr; e.len = len;
    exp_ar.push_back(e);
  endtask

  task automatic push_burst(input int port, input logic [3:0] id, input logic [63:0] base,
                            input int nbeats, input int len, input int err_beat);
    r_exp_t e;
    for (int j = 0; j < nbeats; j++) begin
      e.port = port; e.id = id; e.data = base + 64'(j);
      e.resp = (j == err_beat) ? 2'b10 : 2'b00;
      e.last = (j == len);
      exp_r.push_back(e);
    end
  endtask

  // Requester: raise AR, hold until accepted, then drop. Starts and ends at posedge+1.
  task automatic req(input int m, input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    bit done;
    done = 1'b0;
    io_s_axi_ar_valid[m] = 1'b1;
    io_s_axi_ar_bits_id[m*IW +: IW] = id;
    io_s_axi_ar_bits_addr[m*AW +: AW] = addr;
    io_s_axi_ar_bits_len[m*8 +: 8] = len;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clock);
      if (!reset && io_s_axi_ar_ready[m]) done = 1'b1;
    end
    if (!done) chk(1'b0, "req_timeout", 64'(m), 64'(m));
    @(posedge clock); #1;
    io_s_axi_ar_valid[m] = 1'b0;
  endtask

  // Downstream memory: accept one AR after `delay` stalled cycles, return nsend beats base+k, echoing the id.
  task automatic serve(input int delay, input logic [63:0] base, input int nsend, input int err_beat);
    logic [3:0] id;
    logic [7:0] len;
    bit seen, got;
    io_m_axi_ar_ready = (delay == 0);
    seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clock);
      if (io_m_axi_ar_valid) seen = 1'b1;
    end
    if (!seen) begin
      chk(1'b0, "ar_timeout", 64'd0, 64'd1);
      return;
    end
    for (int d = 0; d < delay; d++) begin
      chk(io_s_axi_ar_ready == '0, "ar_rdy_held", 64'(io_s_axi_ar_ready), 64'd0);
      @(posedge clock); #1;
      if (d == delay - 1) io_m_axi_ar_ready = 1'b1;
      @(negedge clock);
    end
    id  = io_m_axi_ar_bits_id;
    len = io_m_axi_ar_bits_len;
    @(posedge clock); #1;
    io_m_axi_ar_ready = 1'b0;
    for (int b = 0; b < nsend; b++) begin
      io_m_axi_r_valid     = 1'b1;
      io_m_axi_r_bits_id   = id;
      io_m_axi_r_bits_data = base + 64'(b);
      io_m_axi_r_bits_resp = (b == err_beat) ? 2'b10 : 2'b00;
      io_m_axi_r_bits_last = (b == int'(len));
      got = 1'b0;
      for (int n = 0; n < 300 && !got; n++) begin
        @(negedge clock);
        if (io_m_axi_r_ready) got = 1'b1;
      end
      if (!got) chk(1'b0, "r_timeout", 64'(b), 64'(b));
      @(posedge clock); #1;
    end
    io_m_axi_r_valid     = 1'b0;
    io_m_axi_r_bits_last = 1'b0;
  endtask

  task automatic chk_outs_zero(input string name);
    chk({io_s_axi_ar_ready, io_s_axi_r_valid, io_m_axi_ar_valid, io_m_axi_r_ready} == '0, name,
        64'({io_s_axi_ar_ready, io_s_axi_r_valid, io_m_axi_ar_valid, io_m_axi_r_ready}), 64'd0);
  endtask

  task automatic apply_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    #1 chk_outs_zero("reset_outs");
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Monitor: compares every handshake against the queues and polices routing/stability.
  logic        ar_pend = 1'b0;
  logic [3:0]  pend_id;
  logic [31:0] pend_addr;
  logic [7:0]  pend_len;
  logic        after_last = 1'b0;

  always @(negedge clock) begin
    ar_exp_t ea;
    r_exp_t  er;
    logic [NM-1:0] oh;
    if (reset) begin
      ar_pend    = 1'b0;
      after_last = 1'b0;
    end else begin
      if (ar_pend) begin
        chk(io_m_axi_ar_valid, "ar_valid_hold", 64'(io_m_axi_ar_valid), 64'd1);
        chk(io_m_axi_ar_bits_addr == pend_addr && io_m_axi_ar_bits_id == pend_id &&
            io_m_axi_ar_bits_len == pend_len, "ar_stable", 64'(io_m_axi_ar_bits_addr), 64'(pend_addr));
      end
      if (io_m_axi_ar_valid && io_m_axi_ar_ready) begin
        if (exp_ar.size() == 0) begin
          chk(1'b0, "ar_unexpected", 64'(io_m_axi_ar_bits_addr), 64'd0);
        end else begin
          ea = exp_ar.pop_front();
          oh = '0; oh[ea.port] = 1'b1;
          chk(io_m_axi_ar_bits_addr == ea.addr, "ar_addr", 64'(io_m_axi_ar_bits_addr), 64'(ea.addr));
          chk(io_m_axi_ar_bits_id == ea.id, "ar_id", 64'(io_m_axi_ar_bits_id), 64'(ea.id));
          chk(io_m_axi_ar_bits_len == ea.len, "ar_len", 64'(io_m_axi_ar_bits_len), 64'(ea.len));
          chk(io_s_axi_ar_ready == oh, "ar_grant", 64'(io_s_axi_ar_ready), 64'(oh));
        end
      end
      ar_pend   = io_m_axi_ar_valid && !io_m_axi_ar_ready;
      pend_id   = io_m_axi_ar_bits_id;
      pend_addr = io_m_axi_ar_bits_addr;
      pend_len  = io_m_axi_ar_bits_len;

      if (after_last)
        chk(!io_m_axi_ar_valid && !io_m_axi_r_ready, "turnaround",
            64'({io_m_axi_ar_valid, io_m_axi_r_ready}), 64'd0);
      after_last = 1'b0;

      if (io_m_axi_r_valid) begin
        if (exp_r.size() == 0) begin
          chk(1'b0, "r_unexpected", io_m_axi_r_bits_data, 64'd0);
        end else begin
          er = exp_r[0];
          oh = '0; oh[er.port] = 1'b1;
          chk(io_s_axi_r_valid == oh, "r_route", 64'(io_s_axi_r_valid), 64'(oh));
          chk(io_m_axi_r_ready == io_s_axi_r_ready[er.port], "r_ready_mirror",
              64'(io_m_axi_r_ready), 64'(io_s_axi_r_ready[er.port]));
          if (io_m_axi_r_ready) begin
            void'(exp_r.pop_front());
            chk(io_s_axi_r_bits_data == er.data, "r_data", io_s_axi_r_bits_data, er.data);
            chk(io_s_axi_r_bits_id == er.id, "r_id", 64'(io_s_axi_r_bits_id), 64'(er.id));
            chk(io_s_axi_r_bits_resp == er.resp, "r_resp", 64'(io_s_axi_r_bits_resp), 64'(er.resp));
            chk(io_s_axi_r_bits_last == er.last, "r_last", 64'(io_s_axi_r_bits_last), 64'(er.last));
            after_last = er.last;
          end
        end
      end else if (io_s_axi_r_valid != '0) begin
        chk(1'b0, "r_stray", 64'(io_s_axi_r_valid), 64'd0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    io_s_axi_ar_valid = '0; io_s_axi_ar_bits_id = '0; io_s_axi_ar_bits_addr = '0;
    io_s_axi_ar_bits_len = '0; io_s_axi_r_ready = '1;
    io_m_axi_ar_ready = 1'b0; io_m_axi_r_valid = 1'b0; io_m_axi_r_bits_id = '0;
    io_m_axi_r_bits_data = '0; io_m_axi_r_bits_resp = '0; io_m_axi_r_bits_last = 1'b0;
    #1 chk_outs_zero("reset_init");
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Single len=0 burst from s0; AR appears after one arbitration cycle.
    push_ar(0, 4'h0, 32'h100, 8'd0);
    push_burst(0, 4'h0, 64'hDEAD_BEEF_0000_0001, 1, 0, -1);
    fork
      req(0, 4'h0, 32'h100, 8'd0);
      serve(0, 64'hDEAD_BEEF_0000_0001, 1, -1);
      begin
        @(negedge clock);
        chk(!io_m_axi_ar_valid, "arb_cycle", 64'(io_m_axi_ar_valid), 64'd0);
        @(negedge clock);
        chk(io_m_axi_ar_valid && io_m_axi_ar_bits_addr == 32'h100, "ar_latency",
            64'(io_m_axi_ar_bits_addr), 64'h100);
      end
    join

    // Both requesters continuous, len=3: grants 0,1,0,1; SLVERR mid-burst does not end it.
    apply_reset();
    push_ar(0, 4'h3, 32'h4000, 8'd3); push_burst(0, 4'h3, 64'h1000, 4, 3, -1);
    push_ar(1, 4'h6, 32'h8000, 8'd3); push_burst(1, 4'h6, 64'h2000, 4, 3, 1);
    push_ar(0, 4'h3, 32'h4040, 8'd3); push_burst(0, 4'h3, 64'h3000, 4, 3, -1);
    push_ar(1, 4'h6, 32'h8040, 8'd3); push_burst(1, 4'h6, 64'h4000, 4, 3, -1);
    fork
      begin req(0, 4'h3, 32'h4000, 8'd3); req(0, 4'h3, 32'h4040, 8'd3); end
      begin req(1, 4'h6, 32'h8000, 8'd3); req(1, 4'h6, 32'h8040, 8'd3); end
      begin
        serve(0, 64'h1000, 4, -1);
        serve(0, 64'h2000, 4, 1);
        serve(0, 64'h3000, 4, -1);
        serve(0, 64'h4000, 4, -1);
      end
    join

    // ar_ready stalled 5 cycles; s1 id 0xA passes through both directions.
    apply_reset();
    push_ar(1, 4'hA, 32'h2000, 8'd0);
    push_burst(1, 4'hA, 64'h0000_00AA_0000_0000, 1, 0, -1);
    fork
      req(1, 4'hA, 32'h2000, 8'd0);
      serve(5, 64'h0000_00AA_0000_0000, 1, -1);
    join

    // s0 r_ready 1,0,0,1 during a len=3 burst: order kept, nothing lost or duplicated.
    push_ar(0, 4'h2, 32'h5000, 8'd3);
    push_burst(0, 4'h2, 64'h40, 4, 3, -1);
    fork
      req(0, 4'h2, 32'h5000, 8'd3);
      serve(0, 64'h40, 4, -1);
      begin
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
          @(negedge clock);
          if (io_s_axi_r_valid[0]) seen = 1'b1;
        end
        if (!seen) chk(1'b0, "rtoggle_timeout", 64'd0, 64'd1);
        @(posedge clock); #1 io_s_axi_r_ready[0] = 1'b0;
        @(posedge clock); #1 io_s_axi_r_ready[0] = 1'b0;
        @(posedge clock); #1 io_s_axi_r_ready[0] = 1'b1;
      end
    join

    // Reset mid-DATA after 2 of 4 beats; s1's pending request is then served first.
    push_ar(0, 4'h1, 32'h6000, 8'd3);
    push_burst(0, 4'h1, 64'h600, 2, 3, -1);
    push_ar(1, 4'h5, 32'h7000, 8'd0);
    push_burst(1, 4'h5, 64'h77, 1, 0, -1);
    fork
      req(0, 4'h1, 32'h6000, 8'd3);
      begin @(posedge clock); #1 req(1, 4'h5, 32'h7000, 8'd0); end
      begin
        serve(0, 64'h600, 2, -1);
        io_m_axi_r_valid = 1'b1;
        reset = 1'b1;
        #1 chk_outs_zero("reset_mid_data");
        io_m_axi_r_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        serve(0, 64'h77, 1, -1);
      end
    join

    repeat (3) @(posedge clock);
    #1;
    chk(exp_ar.size() == 0, "ar_queue_empty", 64'(exp_ar.size()), 64'd0);
    chk(exp_r.size() == 0, "r_queue_empty", 64'(exp_r.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
